// File: rtl/mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// mem_loader_pkg
// Shared definitions for the program-image loader, the RAM model and CPU tests:
//   - ld_state_e     : loader FSM state encoding
//   - BURST_BYTES    : bytes per full burst for the default EXTRA field width
//   - burst_bytes()  : bytes per full burst for a given EXTRA width
//   - burst_data_w() : width of the packed burst data bus for a given EXTRA width
// -----------------------------------------------------------------------------
package mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WRITE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } ld_state_e;

    localparam int unsigned DEFAULT_EXTRA = 32'd4;
    localparam int unsigned BURST_BYTES   = 32'd1 << DEFAULT_EXTRA;

    // Number of bytes in a full burst when the length field is 'extra' bits wide.
    function automatic int unsigned burst_bytes(input int unsigned extra);
        return 32'd1 << extra;
    endfunction

    // Width in bits of the little-endian packed burst data bus.
    function automatic int unsigned burst_data_w(input int unsigned extra);
        return burst_bytes(extra) * 32'd8;
    endfunction

endpackage

// File: rtl/mem_loader_pack.sv
// -----------------------------------------------------------------------------
// mem_loader_pack
// Byte-lane packing register for one burst. Each pushed byte lands in the lane
// selected by the current count, then the count advances. A clear zeroes all
// lanes and the count, so lanes beyond the burst length always read as zero.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clear_i  zero lanes and count (takes priority over push_i)
//   push_i   store byte_i at lane count_o, count_o++
//   byte_i   byte to store
//   lanes_o  packed burst bytes, byte i at [8i+7:8i]
//   count_o  number of bytes held (0 .. 2**EXTRA)
// -----------------------------------------------------------------------------
module mem_loader_pack
    import mem_loader_pkg::*;
#(
    parameter  int unsigned EXTRA = 4,
    localparam int unsigned DW    = burst_data_w(EXTRA),
    localparam int unsigned CW    = EXTRA + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [7:0]    byte_i,
    output logic [DW-1:0] lanes_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] lanes_q, lanes_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for the lane register and byte count.
    always_comb begin
        lanes_d = lanes_q;
        count_d = count_q;
        if (clear_i) begin
            lanes_d = {DW{1'b0}};
            count_d = {CW{1'b0}};
        end else if (push_i) begin
            lanes_d[{count_q[EXTRA-1:0], 3'b000} +: 8] = byte_i;
            count_d = count_q + CW'(1);
        end else begin
            lanes_d = lanes_q;
            count_d = count_q;
        end
    end

    // Lane register and count state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lanes_q <= {DW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            lanes_q <= lanes_d;
            count_q <= count_d;
        end
    end

    assign lanes_o = lanes_q;
    assign count_o = count_q;

endmodule

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
// Loads a program image from a valid/ready byte stream into RAM through a
// genrom-style burst write port. Bytes are packed into bursts of up to
// 2**EXTRA bytes; every burst is bounds-checked against upper_bound_i before
// it is written, and a memory fault reported the cycle after the write
// aborts the load with a sticky error.
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        pulse: begin a load at start_addr_i (ignored while busy)
//   start_addr_i   first byte address of the image
//   upper_bound_i  highest writable byte address (inclusive)
//   in_data_i      stream byte
//   in_valid_i     stream byte valid
//   in_last_i      final byte of the image (qualified by in_valid_i)
//   in_ready_o     loader accepts a byte this cycle
//   mem_addr_o     burst base address
//   mem_extra_o    burst byte count minus one
//   mem_data_o     burst bytes, little-endian, unused lanes zero
//   mem_we_o       one-cycle write strobe per burst
//   mem_error_i    memory fault, valid the cycle after mem_we_o
//   busy_o         load in progress
//   done_o         one-cycle pulse: image fully written
//   error_o        sticky fault flag, cleared by the next accepted start
// Timing: a burst of N bytes takes N FILL cycles, one WRITE cycle (strobe
// high) and one WAIT cycle (fault sampled).
// -----------------------------------------------------------------------------
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter  int unsigned AW    = 4,
    parameter  int unsigned EXTRA = 4,
    localparam int unsigned DW    = burst_data_w(EXTRA),
    localparam int unsigned NB    = burst_bytes(EXTRA),
    localparam int unsigned CW    = EXTRA + 1,
    localparam int unsigned ABW   = AW + 1,
    localparam int unsigned BW    = AW + EXTRA + 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [ABW-1:0]   start_addr_i,
    input  logic [ABW-1:0]   upper_bound_i,
    input  logic [7:0]       in_data_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic [ABW-1:0]   mem_addr_o,
    output logic [EXTRA-1:0] mem_extra_o,
    output logic [DW-1:0]    mem_data_o,
    output logic             mem_we_o,
    input  logic             mem_error_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    ld_state_e        state_q;
    logic [ABW-1:0]   base_q;
    logic             last_q;
    logic             bound_fail_q;
    logic             in_ready_q;
    logic             mem_we_q;
    logic [ABW-1:0]   mem_addr_q;
    logic [EXTRA-1:0] mem_extra_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic             accept_s;
    logic             burst_end_s;
    logic             pack_clear_s;
    logic [CW-1:0]    count_s;
    logic [BW-1:0]    end_addr_s;
    logic             over_s;

    // in_ready_q is only ever high in FILL, so it fully qualifies the handshake.
    assign accept_s    = in_valid_i & in_ready_q;
    assign burst_end_s = accept_s & (in_last_i | (count_s == CW'(NB - 1)));

    // While the closing byte is accepted count_s still holds N-1, so
    // base + count_s is the last address the burst would touch. The wide
    // adder makes any carry out of the address width compare as out of range.
    assign end_addr_s  = BW'(base_q) + BW'(count_s);
    assign over_s      = (end_addr_s > BW'(upper_bound_i));

    // Packing register is emptied on an accepted start and after a clean write.
    always_comb begin
        pack_clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pack_clear_s = 1'b1;
                end else begin
                    pack_clear_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (!mem_error_i) begin
                    pack_clear_s = 1'b1;
                end else begin
                    pack_clear_s = 1'b0;
                end
            end
            default: pack_clear_s = 1'b0;
        endcase
    end

    mem_loader_pack #(
        .EXTRA (EXTRA)
    ) u_pack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (pack_clear_s),
        .push_i  (accept_s),
        .byte_i  (in_data_i),
        .lanes_o (mem_data_o),
        .count_o (count_s)
    );

    // Loader FSM with registered handshake, strobe and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            base_q       <= {ABW{1'b0}};
            last_q       <= 1'b0;
            bound_fail_q <= 1'b0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ABW{1'b0}};
            mem_extra_q  <= {EXTRA{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q       <= start_addr_i;
                        error_q      <= 1'b0;
                        last_q       <= 1'b0;
                        bound_fail_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_FILL;
                    end else begin
                        in_ready_q   <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                ST_FILL: begin
                    // The strobe is launched on the edge that accepts the closing
                    // byte so that the WRITE cycle carries mem_we_o.
                    if (burst_end_s) begin
                        in_ready_q   <= 1'b0;
                        last_q       <= in_last_i;
                        bound_fail_q <= over_s;
                        state_q      <= ST_WRITE;
                        if (!over_s) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= base_q;
                            mem_extra_q <= count_s[EXTRA-1:0];
                        end else begin
                            mem_we_q    <= 1'b0;
                        end
                    end else begin
                        in_ready_q   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (bound_fail_q) begin
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_error_i) begin
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        base_q <= base_q + ABW'(count_s);
                        if (last_q) begin
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= ST_FILL;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_extra_o = mem_extra_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
// Directed bench for mem_loader (AW=4, EXTRA=4) with a small byte RAM model
// behind the burst write port and an injectable memory fault.
// -----------------------------------------------------------------------------
module tb_mem_loader;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [4:0]   start_addr;
    logic [4:0]   upper_bound;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [4:0]   mem_addr;
    logic [3:0]   mem_extra;
    logic [127:0] mem_data;
    logic         mem_we;
    logic         mem_error;
    logic         busy;
    logic         done;
    logic         error;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:31];
    logic [4:0] log_addr  [0:7];
    logic [3:0] log_extra [0:7];
    int         we_cnt = 0;
    bit         inj = 1'b0;
    logic [7:0] img [0:19];
    int         w0;

    mem_loader #(.AW(4), .EXTRA(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .start_addr_i  (start_addr),
        .upper_bound_i (upper_bound),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .in_last_i     (in_last),
        .in_ready_o    (in_ready),
        .mem_addr_o    (mem_addr),
        .mem_extra_o   (mem_extra),
        .mem_data_o    (mem_data),
        .mem_we_o      (mem_we),
        .mem_error_i   (mem_error),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: writes burst lanes, logs bursts, reports fault the cycle after a strobe.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 16; i++) begin
                if (i <= int'(mem_extra) && (int'(mem_addr) + i) < 32)
                    ram[int'(mem_addr) + i] <= mem_data[8*i +: 8];
            end
            if (we_cnt < 8) begin
                log_addr[we_cnt]  <= mem_addr;
                log_extra[we_cnt] <= mem_extra;
            end
            we_cnt <= we_cnt + 1;
        end
        mem_error <= mem_we & inj;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] addr, input logic [4:0] ub);
        start_addr  = addr;
        upper_bound = ub;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_end(input int max);
        int n;
        n = 0;
        while (!done && !error && n < max) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = 5'd0; upper_bound = 5'd31;
        in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0; mem_error = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        for (int i = 0; i < 20; i++) img[i] = 8'(i * 37 + 5);

        // Reset state
        repeat (3) tick();
        chk("rst_flags", {123'd0, in_ready, mem_we, busy, done, error}, 128'd0);
        chk("rst_addr",  {123'd0, mem_addr}, 128'd0);
        chk("rst_extra", {124'd0, mem_extra}, 128'd0);
        chk("rst_data",  mem_data, 128'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_ready", {127'd0, in_ready}, 128'd0);
        chk("idle_busy",  {127'd0, busy}, 128'd0);

        // 5-byte image at address 0
        do_start(5'd0, 5'd31);
        chk("a_busy",  {127'd0, busy}, 128'd1);
        chk("a_ready", {127'd0, in_ready}, 128'd1);
        send(8'h00, 1'b0); send(8'h61, 1'b0); send(8'h73, 1'b0);
        send(8'h6D, 1'b0); send(8'h01, 1'b1);
        chk("a_we",       {127'd0, mem_we}, 128'd1);
        chk("a_addr",     {123'd0, mem_addr}, 128'd0);
        chk("a_extra",    {124'd0, mem_extra}, 128'd4);
        chk("a_data",     mem_data, 128'h016D736100);
        chk("a_ready_lo", {127'd0, in_ready}, 128'd0);
        tick();
        chk("a_wait_done", {127'd0, done}, 128'd0);
        chk("a_wait_we",   {127'd0, mem_we}, 128'd0);
        tick();
        chk("a_done",  {127'd0, done}, 128'd1);
        chk("a_error", {127'd0, error}, 128'd0);
        tick();
        chk("a_idle", {126'd0, busy, done}, 128'd0);
        chk("a_wecnt", 128'(we_cnt), 128'd1);

        // 20-byte image: full burst then a 4-byte tail
        w0 = we_cnt;
        do_start(5'd0, 5'd31);
        for (int i = 0; i < 20; i++) send(img[i], i == 19);
        wait_end(10);
        chk("b_done",  {127'd0, done}, 128'd1);
        chk("b_error", {127'd0, error}, 128'd0);
        chk("b_wecnt", 128'(we_cnt - w0), 128'd2);
        chk("b_addr0",  {123'd0, log_addr[w0]}, 128'd0);
        chk("b_extra0", {124'd0, log_extra[w0]}, 128'd15);
        chk("b_addr1",  {123'd0, log_addr[w0+1]}, 128'd16);
        chk("b_extra1", {124'd0, log_extra[w0+1]}, 128'd3);
        for (int i = 0; i < 20; i++) chk($sformatf("b_ram%0d", i), {120'd0, ram[i]}, {120'd0, img[i]});
        tick();

        // Burst crosses upper_bound: no write, sticky error
        w0 = we_cnt;
        do_start(5'd28, 5'd31);
        for (int i = 0; i < 6; i++) send(img[i], i == 5);
        chk("c_no_we", {127'd0, mem_we}, 128'd0);
        wait_end(10);
        chk("c_error", {127'd0, error}, 128'd1);
        repeat (3) tick();
        chk("c_busy",   {127'd0, busy}, 128'd0);
        chk("c_ready",  {127'd0, in_ready}, 128'd0);
        chk("c_sticky", {127'd0, error}, 128'd1);
        chk("c_wecnt",  128'(we_cnt - w0), 128'd0);

        // Memory fault on the first burst
        w0 = we_cnt;
        inj = 1'b1;
        do_start(5'd0, 5'd31);
        chk("d_err_clr", {127'd0, error}, 128'd0);
        for (int i = 0; i < 16; i++) send(img[i], 1'b0);
        wait_end(10);
        inj = 1'b0;
        in_data = 8'h55; in_valid = 1'b1;
        repeat (4) tick();
        chk("d_error",  {127'd0, error}, 128'd1);
        chk("d_ready",  {127'd0, in_ready}, 128'd0);
        chk("d_busy",   {127'd0, busy}, 128'd0);
        chk("d_wecnt",  128'(we_cnt - w0), 128'd1);
        in_valid = 1'b0;
        do_start(5'd8, 5'd31);
        chk("d_restart_err", {127'd0, error}, 128'd0);
        for (int i = 0; i < 5; i++) send(img[i + 10], i == 4);
        wait_end(10);
        chk("d_done",   {127'd0, done}, 128'd1);
        chk("d_addr",   {123'd0, log_addr[w0+1]}, 128'd8);
        chk("d_extra",  {124'd0, log_extra[w0+1]}, 128'd4);
        for (int i = 0; i < 5; i++) chk($sformatf("d_ram%0d", i + 8), {120'd0, ram[i + 8]}, {120'd0, img[i + 10]});
        tick();

        // Reset in the middle of FILL
        w0 = we_cnt;
        do_start(5'd0, 5'd31);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("e_rst_flags", {123'd0, in_ready, mem_we, busy, done, error}, 128'd0);
        chk("e_rst_data",  mem_data, 128'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("e_wecnt", 128'(we_cnt - w0), 128'd0);
        chk("e_idle",  {126'd0, busy, in_ready}, 128'd0);
        do_start(5'd20, 5'd31);
        for (int i = 0; i < 5; i++) send(img[i], i == 4);
        wait_end(10);
        chk("e_done",  {127'd0, done}, 128'd1);
        chk("e_error", {127'd0, error}, 128'd0);
        chk("e_addr",  {123'd0, log_addr[w0]}, 128'd20);
        chk("e_extra", {124'd0, log_extra[w0]}, 128'd4);
        for (int i = 0; i < 5; i++) chk($sformatf("e_ram%0d", i + 20), {120'd0, ram[i + 20]}, {120'd0, img[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
